// File: rtl/sram_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bridge_pkg
//  Description : Shared types and constants for the 32-bit to 16-bit SRAM
//                bridge: FSM state encoding, legal WAIT_CYCLES range and
//                half-word phase selectors.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_bridge_pkg;

    // Bridge FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    // Legal range of cycles per half-word phase
    localparam int c_WAIT_MIN = 2;
    localparam int c_WAIT_MAX = 15;

    // Half-word phase selectors, also the LSB of the SRAM half-word address
    localparam logic PH_LO = 1'b0;
    localparam logic PH_HI = 1'b1;

    // Out-of-range phase lengths are pulled into the legal window so the
    // 4-bit phase counter can never overflow.
    function automatic int clamp_wait(input int w);
        if (w < c_WAIT_MIN) return c_WAIT_MIN;
        if (w > c_WAIT_MAX) return c_WAIT_MAX;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sram_phase_timer
//  Description : Per-phase cycle counter. Counts 0..WAIT_CYCLES-1 and holds
//                at the final value; 'start' clears it back to 0 for the
//                next phase. 'last' flags the final (write-hold) cycle.
//  Ports       : clk   - clock, rising edge
//                rst   - asynchronous active-low reset
//                start - clear counter at the next edge
//                last  - high during the final cycle of a phase
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_phase_timer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic last
);

    localparam logic [3:0] c_LAST = 4'(WAIT_CYCLES - 1);

    logic [3:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= '0;
        end else if (!last) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign last = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bridge
//  Description : Executes 32-bit CPU data accesses as one or two half-word
//                cycles on a 16-bit asynchronous SRAM. MemReady is a busy
//                flag; DataOut holds the most recently read word.
//  Ports       : clk, rst (async active-low)
//                Address/DataIn/ReadEnable/WriteEnable - CPU request side
//                DataOut/MemReady                      - CPU response side
//                SramAddr/SramDout/SramDin/SramCe/SramOe/SramWe/SramBe
//                                                      - SRAM pins
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       Address,
    input  logic [31:0]       DataIn,
    input  logic              ReadEnable,
    input  logic [3:0]        WriteEnable,
    output logic [31:0]       DataOut,
    output logic              MemReady,
    output logic [ADDR_W-1:0] SramAddr,
    output logic [15:0]       SramDout,
    input  logic [15:0]       SramDin,
    output logic              SramCe,
    output logic              SramOe,
    output logic              SramWe,
    output logic [1:0]        SramBe
);

    localparam int c_WAIT = clamp_wait(WAIT_CYCLES);

    state_t              r_state;
    logic [ADDR_W-2:0]   r_addr;
    logic [31:0]         r_data;
    logic [3:0]          r_we;
    logic                r_is_wr;
    logic [15:0]         r_lo_hold;
    logic [31:0]         r_dout;
    logic                r_busy;

    logic                w_req;
    logic                w_last;
    logic                w_start;
    logic                w_hi_needed;
    logic                w_phase;
    logic                w_unused_addr;

    // Word-granular bridge: byte offset and bits above the SRAM range are
    // intentionally ignored.
    assign w_unused_addr = ^{Address[31:ADDR_W+1], Address[1:0]};

    assign w_req       = ReadEnable | (|WriteEnable);
    // Reads always need the upper half-word; writes only if a lane is set.
    assign w_hi_needed = ~r_is_wr | (|r_we[3:2]);
    assign w_phase     = (r_state == HI) ? PH_HI : PH_LO;
    // Counter is held at zero while idle and cleared at every phase end,
    // so each new phase starts counting from 0.
    assign w_start     = (r_state == IDLE) | w_last;

    sram_phase_timer #(
        .WAIT_CYCLES (c_WAIT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (w_start),
        .last  (w_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_data    <= '0;
            r_we      <= '0;
            r_is_wr   <= 1'b0;
            r_lo_hold <= '0;
            r_dout    <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr  <= Address[ADDR_W:2];
                        r_data  <= DataIn;
                        r_we    <= WriteEnable;
                        // Any byte enable makes it a write; a concurrent
                        // read is dropped.
                        r_is_wr <= |WriteEnable;
                        r_busy  <= 1'b1;
                        if ((|WriteEnable) && (WriteEnable[1:0] == 2'b00)) begin
                            r_state <= HI;
                        end else begin
                            r_state <= LO;
                        end
                    end
                end
                LO: begin
                    if (w_last) begin
                        if (!r_is_wr) begin
                            r_lo_hold <= SramDin;
                        end
                        if (w_hi_needed) begin
                            r_state <= HI;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                HI: begin
                    if (w_last) begin
                        if (!r_is_wr) begin
                            r_dout <= {SramDin, r_lo_hold};
                        end
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // SRAM pins decode from state and latched request only; all zero in IDLE.
    always_comb begin
        SramAddr = '0;
        SramDout = '0;
        SramBe   = 2'b00;
        SramCe   = 1'b0;
        SramOe   = 1'b0;
        SramWe   = 1'b0;
        if (r_state != IDLE) begin
            SramCe   = 1'b1;
            SramAddr = {r_addr, w_phase};
            if (r_is_wr) begin
                SramBe   = (w_phase == PH_HI) ? r_we[3:2] : r_we[1:0];
                SramDout = (w_phase == PH_HI) ? r_data[31:16] : r_data[15:0];
                // Released in the final cycle to give address/data hold.
                SramWe   = ~w_last;
            end else begin
                SramOe   = 1'b1;
                SramBe   = 2'b11;
            end
        end
    end

    assign DataOut  = r_dout;
    assign MemReady = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_sram_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bridge
//  Description : Self-checking bench for sram_bridge with a behavioural
//                16-bit SRAM and a word-level reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bridge;

    localparam int ADDR_W = 18;
    localparam int W      = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [31:0]       Address = '0;
    logic [31:0]       DataIn = '0;
    logic              ReadEnable = 1'b0;
    logic [3:0]        WriteEnable = '0;
    logic [31:0]       DataOut;
    logic              MemReady;
    logic [ADDR_W-1:0] SramAddr;
    logic [15:0]       SramDout;
    logic [15:0]       SramDin;
    logic              SramCe;
    logic              SramOe;
    logic              SramWe;
    logic [1:0]        SramBe;

    int n_cmp  = 0;
    int n_fail = 0;

    // SRAM device model and the bench's own view of memory contents
    logic [15:0] sram    [0:(1<<ADDR_W)-1];
    logic [15:0] ref_mem [0:(1<<ADDR_W)-1];
    logic [31:0] model_dout = '0;

    logic              pre_we = 1'b0;
    logic [ADDR_W-1:0] pre_addr = '0;
    logic [15:0]       pre_data = '0;

    always #5 clk = ~clk;

    sram_bridge #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Address     (Address),
        .DataIn      (DataIn),
        .ReadEnable  (ReadEnable),
        .WriteEnable (WriteEnable),
        .DataOut     (DataOut),
        .MemReady    (MemReady),
        .SramAddr    (SramAddr),
        .SramDout    (SramDout),
        .SramDin     (SramDin),
        .SramCe      (SramCe),
        .SramOe      (SramOe),
        .SramWe      (SramWe),
        .SramBe      (SramBe)
    );

    assign SramDin = (SramCe && SramOe) ? sram[SramAddr] : 16'h0000;

    always @(posedge clk) begin
        if (pre_we) begin
            sram[pre_addr] <= pre_data;
        end else if (SramCe && SramWe) begin
            if (SramBe[0]) sram[SramAddr][7:0]  <= SramDout[7:0];
            if (SramBe[1]) sram[SramAddr][15:8] <= SramDout[15:8];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // One access from request to first idle cycle; called at a negedge.
    task automatic run_access(input logic [31:0] addr, input logic [31:0] din,
                              input logic re, input logic [3:0] we,
                              input bit hold, input string tag);
        logic [ADDR_W-2:0] wa;
        logic              ph[$];
        bit                is_wr;
        int                busy;
        int                exp_busy;
        logic              p;
        int                k;
        logic [38:0]       obs;
        logic [38:0]       exp_v;
        logic [31:0]       exp_word;
        wa    = addr[ADDR_W:2];
        is_wr = (we != 4'b0000);
        if (!is_wr) begin
            ph.push_back(1'b0);
            ph.push_back(1'b1);
        end else begin
            if (we[1:0] != 2'b00) ph.push_back(1'b0);
            if (we[3:2] != 2'b00) ph.push_back(1'b1);
        end
        exp_busy = ph.size() * W;

        Address = addr; DataIn = din; ReadEnable = re; WriteEnable = we;
        busy = 0;
        for (int c = 0; c < exp_busy + 20; c++) begin
            @(negedge clk);
            if (!hold) begin
                ReadEnable = 1'b0; WriteEnable = 4'b0000;
            end
            if (!MemReady) break;
            if (busy < exp_busy) begin
                p = ph[busy / W];
                k = busy % W;
                obs = {SramCe, SramOe, SramWe, SramBe, SramAddr, SramDout};
                exp_v = {1'b1, !is_wr, (is_wr && k != W-1),
                         (is_wr ? (p ? we[3:2] : we[1:0]) : 2'b11),
                         {wa, p},
                         (is_wr ? (p ? din[31:16] : din[15:0]) : 16'h0000)};
                n_cmp++;
                if (obs !== exp_v) begin
                    n_fail++;
                    $display("FAIL %s pins cyc%0d: got %h expected %h", tag, busy, obs, exp_v);
                end
            end
            busy++;
        end
        ReadEnable = 1'b0; WriteEnable = 4'b0000;

        n_cmp++;
        if (busy !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d expected %0d", tag, busy, exp_busy);
        end

        if (is_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    if (b < 2) ref_mem[{wa, 1'b0}][8*b +: 8] = din[8*b +: 8];
                    else       ref_mem[{wa, 1'b1}][8*(b-2) +: 8] = din[8*b +: 8];
                end
            end
            n_cmp++;
            if ({sram[{wa,1'b1}], sram[{wa,1'b0}]} !== {ref_mem[{wa,1'b1}], ref_mem[{wa,1'b0}]}) begin
                n_fail++;
                $display("FAIL %s sram_word: got %h expected %h", tag,
                         {sram[{wa,1'b1}], sram[{wa,1'b0}]},
                         {ref_mem[{wa,1'b1}], ref_mem[{wa,1'b0}]});
            end
        end else begin
            model_dout = {ref_mem[{wa,1'b1}], ref_mem[{wa,1'b0}]};
        end
        exp_word = model_dout;
        n_cmp++;
        if (DataOut !== exp_word) begin
            n_fail++;
            $display("FAIL %s DataOut: got %h expected %h", tag, DataOut, exp_word);
        end
    endtask

    task automatic test_reset;
        logic [70:0] obs;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) rst = 1'b1;
            @(negedge clk);
            obs = {DataOut, MemReady, SramCe, SramOe, SramWe, SramBe, SramAddr, SramDout};
            n_cmp++;
            if (obs !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %h expected 0", c, obs);
            end
        end
    endtask

    task automatic preload;
        for (int a = 'h80; a < 'hC0; a++) poke(ADDR_W'(a), 16'($urandom));
        poke(18'h80, 16'hBEEF);
        poke(18'h81, 16'hDEAD);
    endtask

    task automatic test_word_read;
        run_access(32'h0000_0100, 32'h0, 1'b1, 4'b0000, 1'b0, "word_read");
        n_cmp++;
        if (DataOut !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_read_const: got %h expected deadbeef", DataOut);
        end
    endtask

    task automatic test_byte_store;
        run_access(32'h0000_0102, 32'h5A5A5A5A, 1'b0, 4'b0100, 1'b0, "byte_store");
        n_cmp++;
        if ({sram[18'h81], sram[18'h80]} !== 32'hDE5ABEEF) begin
            n_fail++;
            $display("FAIL byte_store_const: got %h expected de5abeef", {sram[18'h81], sram[18'h80]});
        end
    endtask

    task automatic test_held_request;
        run_access(32'h0000_0104, 32'h0, 1'b1, 4'b0000, 1'b1, "held_req");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({MemReady, SramCe} !== 2'b00) begin
                n_fail++;
                $display("FAIL held_req_single cyc%0d: got %b expected 00", c, {MemReady, SramCe});
            end
        end
    endtask

    task automatic test_conflict_b2b;
        logic [31:0] d;
        d = $urandom;
        run_access(32'h0000_0108, d, 1'b1, 4'b1111, 1'b0, "conflict_wr");
        run_access(32'h0000_0108, 32'h0, 1'b1, 4'b0000, 1'b0, "b2b_read");
        n_cmp++;
        if (DataOut !== d) begin
            n_fail++;
            $display("FAIL conflict_readback: got %h expected %h", DataOut, d);
        end
    endtask

    task automatic test_reset_mid_hi;
        logic [31:0] d;
        logic [3:0]  obs;
        d = $urandom;
        Address = 32'h0000_010C; DataIn = d; WriteEnable = 4'b1111; ReadEnable = 1'b0;
        for (int c = 0; c < W + 1; c++) begin
            @(negedge clk);
            WriteEnable = 4'b0000;
        end
        n_cmp++;
        if ({SramCe, SramWe, SramAddr[0]} !== 3'b111) begin
            n_fail++;
            $display("FAIL rst_mid_in_hi: got %b expected 111", {SramCe, SramWe, SramAddr[0]});
        end
        rst = 1'b0;
        #1;
        obs = {SramWe, SramCe, MemReady, (DataOut != 32'h0)};
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_drop: got %b (DataOut %h) expected 0000", obs, DataOut);
        end
        model_dout = 32'h0;
        ref_mem[18'h86] = d[15:0];  // LO phase completed before the reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_access(32'h0000_010C, 32'h0, 1'b1, 4'b0000, 1'b0, "post_rst_read");
    endtask

    task automatic test_random;
        logic [31:0] addr;
        logic [31:0] d;
        logic        re;
        logic [3:0]  we;
        int          gap;
        for (int n = 0; n < 40; n++) begin
            addr = ($urandom & 32'hFFF8_0003) | (32'h100 + ($urandom_range(0, 31) << 2));
            d    = $urandom;
            re   = 1'($urandom);
            we   = re ? (($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000)
                      : 4'($urandom_range(1, 15));
            run_access(addr, d, re, we, 1'($urandom), "random");
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        preload;
        test_word_read;
        test_byte_store;
        test_held_request;
        test_conflict_b2b;
        test_reset_mid_hi;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
